// File: rtl/id_ex_if.sv
// ID/EX pipeline register handshake bundle.
// Decode side drives id_* and flush; the stage drives ex_*, stall, bubble_count.
interface id_ex_if #(
  parameter int XLEN = 32
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic [7:0]      id_ctrl;
  logic            flush;

  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  logic [7:0]      ex_ctrl;
  logic            stall;
  logic [15:0]     bubble_count;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
    output id_rs1, id_rs2, id_rd, id_ctrl, flush,
    input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
    input  ex_rs1, ex_rs2, ex_rd, ex_ctrl, stall, bubble_count
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
    input  id_rs1, id_rs2, id_rd, id_ctrl, flush,
    output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
    output ex_rs1, ex_rs2, ex_rd, ex_ctrl, stall, bubble_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Hazard detection and the bubble counter exist only with HAZARD_DETECT_EN.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input logic   clk,
  input logic   rst_n,
  id_ex_if.slave bus
);

  logic            v_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] r1d_q;
  logic [XLEN-1:0] r2d_q;
  logic [XLEN-1:0] imm_q;
  logic [4:0]      rs1_q;
  logic [4:0]      rs2_q;
  logic [4:0]      rd_q;
  logic [7:0]      ctrl_q;
  logic            hz;
  logic            bubble;

`ifdef HAZARD_DETECT_EN
  logic [15:0] cnt_q;

  assign hz = bus.id_valid && v_q && ctrl_q[1] &&
              (rd_q != 5'd0) &&
              (rd_q == bus.id_rs1 || rd_q == bus.id_rs2);
  assign bus.stall = hz && !bus.flush;
  assign bus.bubble_count = cnt_q;

  // flush outranks the hazard, so a squashed slot is not counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else if (hz && !bus.flush && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end
`else
  assign hz = 1'b0;
  assign bus.stall = 1'b0;
  assign bus.bubble_count = 16'd0;
`endif

  assign bubble = bus.flush || hz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= 1'b0;
      pc_q   <= '0;
      r1d_q  <= '0;
      r2d_q  <= '0;
      imm_q  <= '0;
      rs1_q  <= 5'd0;
      rs2_q  <= 5'd0;
      rd_q   <= 5'd0;
      ctrl_q <= 8'd0;
    end else if (bubble) begin
      v_q    <= 1'b0;
      pc_q   <= '0;
      r1d_q  <= '0;
      r2d_q  <= '0;
      imm_q  <= '0;
      rs1_q  <= 5'd0;
      rs2_q  <= 5'd0;
      rd_q   <= 5'd0;
      ctrl_q <= 8'd0;
    end else begin
      v_q    <= bus.id_valid;
      pc_q   <= bus.id_pc;
      r1d_q  <= bus.id_rs1_data;
      r2d_q  <= bus.id_rs2_data;
      imm_q  <= bus.id_imm;
      rs1_q  <= bus.id_rs1;
      rs2_q  <= bus.id_rs2;
      rd_q   <= bus.id_rd;
      ctrl_q <= bus.id_valid ? bus.id_ctrl : 8'd0;
    end
  end

  assign bus.ex_valid    = v_q;
  assign bus.ex_pc       = pc_q;
  assign bus.ex_rs1_data = r1d_q;
  assign bus.ex_rs2_data = r2d_q;
  assign bus.ex_imm      = imm_q;
  assign bus.ex_rs1      = rs1_q;
  assign bus.ex_rs2      = rs2_q;
  assign bus.ex_rd       = rd_q;
  assign bus.ex_ctrl     = ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage.
// Expectations follow whether HAZARD_DETECT_EN is defined for the build.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

`ifdef HAZARD_DETECT_EN
  localparam bit HD = 1'b1;
`else
  localparam bit HD = 1'b0;
`endif

  localparam logic [7:0] LD = 8'h0B;
  localparam logic [7:0] ADD = 8'h41;
  localparam logic [7:0] ST = 8'h14;

  always #5 clk = ~clk;

  id_ex_if #(.XLEN(32)) bus ();

  id_ex_stage #(.XLEN(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
    logic        fl;
    logic        hz;
    logic [15:0] cnt;
  } vec_t;

  vec_t tv[14];

  function automatic vec_t mk(
    input logic v, input logic [31:0] pc,
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [4:0] rd, input logic [7:0] ctrl,
    input logic fl, input logic hz, input logic [15:0] cnt
  );
    vec_t t;
    t.v = v; t.pc = pc; t.rs1 = rs1; t.rs2 = rs2;
    t.rd = rd; t.ctrl = ctrl; t.fl = fl; t.hz = hz;
    t.cnt = cnt;
    return t;
  endfunction

  task automatic chk(
    input string nm, input int idx,
    input logic [31:0] act, input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    bus.id_valid    = t.v;
    bus.id_pc       = t.pc;
    bus.id_rs1_data = t.pc + 32'h1000;
    bus.id_rs2_data = t.pc + 32'h2000;
    bus.id_imm      = ~t.pc;
    bus.id_rs1      = t.rs1;
    bus.id_rs2      = t.rs2;
    bus.id_rd       = t.rd;
    bus.id_ctrl     = t.ctrl;
    bus.flush       = t.fl;
  endtask

  task automatic apply(input vec_t t, input int idx);
    logic b;
    b = t.fl || (HD && t.hz);
    @(negedge clk);
    drive(t);
    #1;
    chk("stall", idx, 32'(bus.stall), 32'(HD && t.hz && !t.fl));
    @(posedge clk);
    #1;
    chk("valid", idx, 32'(bus.ex_valid), b ? 32'd0 : 32'(t.v));
    chk("pc", idx, bus.ex_pc, b ? 32'd0 : t.pc);
    chk("r1d", idx, bus.ex_rs1_data, b ? 32'd0 : t.pc + 32'h1000);
    chk("r2d", idx, bus.ex_rs2_data, b ? 32'd0 : t.pc + 32'h2000);
    chk("imm", idx, bus.ex_imm, b ? 32'd0 : ~t.pc);
    chk("rs1", idx, 32'(bus.ex_rs1), b ? 32'd0 : 32'(t.rs1));
    chk("rs2", idx, 32'(bus.ex_rs2), b ? 32'd0 : 32'(t.rs2));
    chk("rd", idx, 32'(bus.ex_rd), b ? 32'd0 : 32'(t.rd));
    chk("ctrl", idx, 32'(bus.ex_ctrl),
        (b || !t.v) ? 32'd0 : 32'(t.ctrl));
    chk("cnt", idx, 32'(bus.bubble_count), HD ? 32'(t.cnt) : 32'd0);
  endtask

  task automatic chk_zero(input int idx);
    chk("rst_valid", idx, 32'(bus.ex_valid), 32'd0);
    chk("rst_pc", idx, bus.ex_pc, 32'd0);
    chk("rst_r1d", idx, bus.ex_rs1_data, 32'd0);
    chk("rst_rd", idx, 32'(bus.ex_rd), 32'd0);
    chk("rst_ctrl", idx, 32'(bus.ex_ctrl), 32'd0);
    chk("rst_cnt", idx, 32'(bus.bubble_count), 32'd0);
    chk("rst_stall", idx, 32'(bus.stall), 32'd0);
  endtask

  initial begin
    tv[0]  = mk(1, 32'h100, 5'd1, 5'd2, 5'd5,  LD,  0, 0, 16'd0);
    tv[1]  = mk(1, 32'h104, 5'd5, 5'd3, 5'd6,  ADD, 0, 1, 16'd1);
    tv[2]  = mk(1, 32'h104, 5'd5, 5'd3, 5'd6,  ADD, 0, 0, 16'd1);
    tv[3]  = mk(1, 32'h108, 5'd0, 5'd0, 5'd0,  LD,  0, 0, 16'd1);
    tv[4]  = mk(1, 32'h10C, 5'd0, 5'd0, 5'd7,  ADD, 0, 0, 16'd1);
    tv[5]  = mk(1, 32'h110, 5'd4, 5'd0, 5'd9,  LD,  0, 0, 16'd1);
    tv[6]  = mk(1, 32'h114, 5'd1, 5'd9, 5'd0,  ST,  1, 1, 16'd1);
    tv[7]  = mk(0, 32'h118, 5'd2, 5'd4, 5'd3,  ADD, 0, 0, 16'd1);
    tv[8]  = mk(1, 32'h11C, 5'd2, 5'd0, 5'd12, LD,  0, 0, 16'd1);
    tv[9]  = mk(0, 32'h120, 5'd12, 5'd1, 5'd4, ADD, 0, 0, 16'd1);
    tv[10] = mk(1, 32'h124, 5'd3, 5'd4, 5'd5,  ADD, 1, 0, 16'd1);
    tv[11] = mk(1, 32'h128, 5'd1, 5'd0, 5'd8,  LD,  0, 0, 16'd1);
    tv[12] = mk(1, 32'h12C, 5'd1, 5'd8, 5'd0,  ST,  0, 1, 16'd2);
    tv[13] = mk(1, 32'h12C, 5'd1, 5'd8, 5'd0,  ST,  0, 0, 16'd2);

    drive(mk(0, 32'h0, 5'd0, 5'd0, 5'd0, 8'h00, 0, 0, 16'd0));
    #2;
    chk_zero(0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      apply(tv[i], i);
    end

    // asynchronous reset mid-cycle with a valid instruction held in EX
    chk("pre_rst_valid", 0, 32'(bus.ex_valid), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero(1);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef HAZARD_DETECT_EN
    @(negedge clk);
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    #1;
    chk("preload", 0, 32'(bus.bubble_count), 32'h0000FFFE);
    apply(mk(1, 32'h200, 5'd0, 5'd0, 5'd5, LD,  0, 0, 16'hFFFE), 20);
    apply(mk(1, 32'h204, 5'd5, 5'd0, 5'd6, ADD, 0, 1, 16'hFFFF), 21);
    apply(mk(1, 32'h208, 5'd0, 5'd0, 5'd5, LD,  0, 0, 16'hFFFF), 22);
    apply(mk(1, 32'h20C, 5'd0, 5'd5, 5'd6, ADD, 0, 1, 16'hFFFF), 23);
    apply(mk(1, 32'h20C, 5'd0, 5'd5, 5'd6, ADD, 0, 0, 16'hFFFF), 24);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
